mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_rr_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package arb_pkg;

  // Which port, if any, currently holds a locked ownership of the memory.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  // Width of the consecutive-grant counter used while a port owns the memory.
  localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner select: the current owner keeps priority while it is
// still requesting; otherwise a conflict goes to the port not granted last.
module arb_rr_pick
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  owner_t     owner,
  output logic [1:0] gnt
);

  // Owner first, then round-robin on a conflict, else the lone requester.
  always_comb begin
    gnt = 2'b00;
    if (owner == OWN0 && req[0]) begin
      gnt = 2'b01;
    end else if (owner == OWN1 && req[1]) begin
      gnt = 2'b10;
    end else if (req == 2'b11) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-cycle memory arbiter (port 0 = CPU, port 1 = loader/DMA)
// with optional bounded locking so one port can run a burst of accesses.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_wd,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_wd,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [LOCK_CNT_W-1:0] MaxCnt = LOCK_CNT_W'(MAX_LOCK);

  owner_t                state, state_nx;
  logic [LOCK_CNT_W-1:0] cnt, cnt_nx, cnt_after;
  logic                  last_gnt;
  logic [1:0]            pick, gnt;

  arb_rr_pick u_pick (
    .req      ({m1_req, m0_req}),
    .last_gnt (last_gnt),
    .owner    (state),
    .gnt      (pick)
  );

  // Grants are suppressed while reset is high so nothing reaches memory.
  assign gnt    = reset ? 2'b00 : pick;
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // Grant count the owner would reach after this cycle's grant, saturating.
  always_comb begin
    cnt_after = LOCK_CNT_W'(1);
    if (state != IDLE) begin
      cnt_after = (cnt >= MaxCnt) ? MaxCnt : cnt + LOCK_CNT_W'(1);
    end
  end

  // Owner FSM next state and lock counter update.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (gnt[0] && m0_lock && !(cnt_after >= MaxCnt && m1_req)) begin
          state_nx = OWN0;
          cnt_nx   = cnt_after;
        end else if (gnt[1] && m1_lock && !(cnt_after >= MaxCnt && m0_req)) begin
          state_nx = OWN1;
          cnt_nx   = cnt_after;
        end
      end
      OWN0: begin
        if (!m0_req || !m0_lock || (cnt_after >= MaxCnt && m1_req)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt_after;
        end
      end
      OWN1: begin
        if (!m1_req || !m1_lock || (cnt_after >= MaxCnt && m0_req)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt_after;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Owner state, lock counter and round-robin history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (gnt[0]) begin
        last_gnt <= 1'b0;
      end else if (gnt[1]) begin
        last_gnt <= 1'b1;
      end
    end
  end

  // Steer the granted port onto the memory bus; bus is quiet otherwise.
  always_comb begin
    mem_we  = 1'b0;
    mem_adr = '0;
    mem_wd  = '0;
    if (gnt[0]) begin
      mem_we  = m0_we;
      mem_adr = m0_adr;
      mem_wd  = m0_wd;
    end else if (gnt[1]) begin
      mem_we  = m1_we;
      mem_adr = m1_adr;
      mem_wd  = m1_wd;
    end
  end

  // Capture read data one cycle after a granted read; rdata holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt[0] && !m0_we;
      m1_rvalid <= gnt[1] && !m1_we;
      if (gnt[0] && !m0_we) begin
        m0_rdata <= mem_rd;
      end
      if (gnt[1] && !m1_we) begin
        m1_rdata <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed per-cycle vectors push expected
// grants and read returns; a negedge monitor pops and compares them.
module tb_mem_arbiter;

  localparam int NONE = 2;

  typedef struct {
    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] adr;
    logic [31:0] wd;
  } port_t;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        we;
  } gnt_exp_t;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic [31:0] m0_adr = '0, m0_wd = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [31:0] m1_adr = '0, m1_wd = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_adr, mem_wd, mem_rd;

  gnt_exp_t    gntQ[$];
  rd_exp_t     rdQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  logic [31:0] memArr [256];
  bit          written [256];

  mem_arbiter #(.MAX_LOCK(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_lock   (m0_lock),
    .m0_adr    (m0_adr),
    .m0_wd     (m0_wd),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_lock   (m1_lock),
    .m1_adr    (m1_adr),
    .m1_wd     (m1_wd),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Memory model: unwritten words read back as 0xA0000000 plus their byte address.
  assign mem_rd = written[mem_adr[9:2]] ? memArr[mem_adr[9:2]]
                                        : 32'hA000_0000 + {mem_adr[31:2], 2'b00};

  // Cycle counter and write commit at the rising edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      memArr[mem_adr[9:2]] = mem_wd;
      written[mem_adr[9:2]] = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic port_t idleP();
    port_t p;
    p.req = 1'b0; p.we = 1'b0; p.lock = 1'b0; p.adr = '0; p.wd = '0;
    return p;
  endfunction

  function automatic port_t rd(input logic [31:0] adr, input logic lock);
    port_t p;
    p.req = 1'b1; p.we = 1'b0; p.lock = lock; p.adr = adr; p.wd = '0;
    return p;
  endfunction

  function automatic port_t wr(input logic [31:0] adr, input logic [31:0] wd, input logic lock);
    port_t p;
    p.req = 1'b1; p.we = 1'b1; p.lock = lock; p.adr = adr; p.wd = wd;
    return p;
  endfunction

  // Drive one cycle of inputs and queue the hand-computed winner and read word.
  task automatic applyStimulus(input port_t p0, input port_t p1, input int expPort,
                               input logic [31:0] expData, input bit expRv);
    gnt_exp_t g;
    rd_exp_t  r;
    port_t    w;
    @(posedge clk);
    #1;
    m0_req = p0.req; m0_we = p0.we; m0_lock = p0.lock; m0_adr = p0.adr; m0_wd = p0.wd;
    m1_req = p1.req; m1_we = p1.we; m1_lock = p1.lock; m1_adr = p1.adr; m1_wd = p1.wd;
    if (expPort != NONE) begin
      if (expPort == 0) w = p0;
      else w = p1;
      g.cyc = cyc; g.port = expPort; g.adr = w.adr; g.wd = w.wd; g.we = w.we;
      gntQ.push_back(g);
      if (!w.we && expRv) begin
        r.cyc = cyc + 1; r.port = expPort; r.data = expData;
        rdQ.push_back(r);
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_m0_gnt"}, m0_gnt, 0);
    checkOutput({tag, "_m1_gnt"}, m1_gnt, 0);
    checkOutput({tag, "_m0_rvalid"}, m0_rvalid, 0);
    checkOutput({tag, "_m1_rvalid"}, m1_rvalid, 0);
    checkOutput({tag, "_m0_rdata"}, m0_rdata, 0);
    checkOutput({tag, "_m1_rdata"}, m1_rdata, 0);
    checkOutput({tag, "_mem_we"}, mem_we, 0);
    checkOutput({tag, "_mem_adr"}, mem_adr, 0);
    checkOutput({tag, "_mem_wd"}, mem_wd, 0);
  endtask

  // Monitor: whenever the DUT shows a grant or rvalid, pop and compare the
  // oldest expectation; any expectation whose cycle has passed is a miss.
  always @(negedge clk) begin
    gnt_exp_t g;
    rd_exp_t  r;
    if (!reset) begin
      if (m0_gnt || m1_gnt) begin
        checkOutput("gnt_onehot", {31'd0, m0_gnt & m1_gnt}, 0);
        if (gntQ.size() == 0) begin
          checkOutput("gnt_unexpected", {30'd0, m1_gnt, m0_gnt}, 0);
        end else begin
          g = gntQ.pop_front();
          checkOutput("gnt_cycle", cyc, g.cyc);
          checkOutput("gnt_port", {31'd0, m1_gnt}, g.port);
          checkOutput("mem_adr", mem_adr, g.adr);
          checkOutput("mem_we", {31'd0, mem_we}, {31'd0, g.we});
          checkOutput("mem_wd", mem_wd, g.wd);
        end
      end
      while (gntQ.size() > 0 && gntQ[0].cyc <= cyc) begin
        checkOutput("gnt_missing", {30'd0, m1_gnt, m0_gnt}, 32'd1 << gntQ[0].port);
        void'(gntQ.pop_front());
      end
      if (m0_rvalid || m1_rvalid) begin
        checkOutput("rvalid_onehot", {31'd0, m0_rvalid & m1_rvalid}, 0);
        if (rdQ.size() == 0) begin
          checkOutput("rvalid_unexpected", {30'd0, m1_rvalid, m0_rvalid}, 0);
        end else begin
          r = rdQ.pop_front();
          checkOutput("rvalid_cycle", cyc, r.cyc);
          checkOutput("rvalid_port", {31'd0, m1_rvalid}, r.port);
          checkOutput("rdata", m1_rvalid ? m1_rdata : m0_rdata, r.data);
        end
      end
      while (rdQ.size() > 0 && rdQ[0].cyc <= cyc) begin
        checkOutput("rvalid_missing", {30'd0, m1_rvalid, m0_rvalid}, 32'd1 << rdQ[0].port);
        void'(rdQ.pop_front());
      end
    end
  end

  // Directed scenario sequence.
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] simultaneous reads after reset");
    applyStimulus(rd(32'h10, 0), rd(32'h14, 0), 0, 32'hA000_0010, 1);
    applyStimulus(idleP(), rd(32'h14, 0), 1, 32'hA000_0014, 1);
    applyStimulus(idleP(), idleP(), NONE, 0, 0);

    $display("[TB] write by m1 then read back by m0");
    applyStimulus(idleP(), wr(32'h20, 32'hDEAD_BEEF, 0), 1, 0, 0);
    applyStimulus(rd(32'h20, 0), idleP(), 0, 32'hDEAD_BEEF, 1);
    applyStimulus(idleP(), idleP(), NONE, 0, 0);
    applyStimulus(idleP(), rd(32'h24, 0), 1, 32'hA000_0024, 1);
    applyStimulus(idleP(), idleP(), NONE, 0, 0);

    $display("[TB] m0 locked burst against pending m1");
    applyStimulus(rd(32'h40, 1), rd(32'h80, 0), 0, 32'hA000_0040, 1);
    applyStimulus(rd(32'h44, 1), rd(32'h80, 0), 0, 32'hA000_0044, 1);
    applyStimulus(rd(32'h48, 1), rd(32'h80, 0), 0, 32'hA000_0048, 1);
    applyStimulus(rd(32'h4C, 1), rd(32'h80, 0), 0, 32'hA000_004C, 1);
    applyStimulus(rd(32'h50, 1), rd(32'h80, 0), 1, 32'hA000_0080, 1);
    applyStimulus(rd(32'h50, 1), idleP(), 0, 32'hA000_0050, 1);
    applyStimulus(rd(32'h54, 1), idleP(), 0, 32'hA000_0054, 1);
    applyStimulus(idleP(), idleP(), NONE, 0, 0);

    $display("[TB] m1 locked alone, counter saturates");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(idleP(), rd(32'h100 + 32'(i * 4), 1), 1, 32'hA000_0100 + 32'(i * 4), 1);
    end
    applyStimulus(rd(32'h30, 0), idleP(), 0, 32'hA000_0030, 1);
    applyStimulus(idleP(), idleP(), NONE, 0, 0);

    $display("[TB] reset pulse while m0 owns with m1 pending");
    applyStimulus(rd(32'h60, 1), idleP(), 0, 32'hA000_0060, 1);
    applyStimulus(rd(32'h64, 1), rd(32'h70, 0), 0, 0, 0);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkAllZero("midreset");
    m0_req = 1'b0; m0_lock = 1'b0; m1_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(rd(32'h68, 0), rd(32'h70, 0), 0, 32'hA000_0068, 1);
    applyStimulus(idleP(), rd(32'h70, 0), 1, 32'hA000_0070, 1);
    applyStimulus(idleP(), idleP(), NONE, 0, 0);

    $display("[TB] idle bus");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(idleP(), idleP(), NONE, 0, 0);
      @(negedge clk);
      checkOutput("idle_mem_we", {31'd0, mem_we}, 0);
      checkOutput("idle_mem_adr", mem_adr, 0);
      checkOutput("idle_gnt", {30'd0, m1_gnt, m0_gnt}, 0);
      checkOutput("idle_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("gnt_queue_drained", gntQ.size(), 0);
    checkOutput("rd_queue_drained", rdQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
